hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage core. Drives the write enables and squash strobes of PC, if_id, id_ex and
//  the EX/MEM and MEM/WB registers. Resolves load-use stalls, taken-branch squashes (with multi-cycle imem
//  in-flight discard), imem-not-ready bubbles and dmem-wait freezes. Also keeps stall and flush performance counters.
// PARAMETERS
//  FLUSH_CYCLES  2   IF-side squash cycles after a taken branch, incl. branch cycle; legal 1..4
//  CNT_W         32  width of perf counters
// PORTS
//  clk             in   1      clock
//  reset           in   1      synchronous, active-high
//  id_rs1          in   5      rs1 of instr in ID
//  id_rs2          in   5      rs2 of instr in ID
//  id_uses_rs1     in   1      ID instr reads rs1
//  id_uses_rs2     in   1      ID instr reads rs2
//  ex_mem_read     in   1      EX instr is a load
//  ex_rd           in   5      rd of EX instr
//  ex_branch_taken in   1      EX resolved taken branch/jump; PC mux selects target externally
//  imem_ready      in   1      fetch data valid this cycle
//  dmem_req        in   1      MEM stage accessing dmem
//  dmem_ready      in   1      dmem access completes this cycle
//  pc_write        out  1      PC load enable
//  if_id_write     out  1      if_id load enable
//  if_id_flush     out  1      if_id loads NOP (32'h00000013) instead of instr_in; implies write
//  id_ex_write     out  1      id_ex load enable
//  id_ex_flush     out  1      id_ex loads bubble (all control zero); implies write
//  back_write      out  1      EX/MEM and MEM/WB load enable
//  stall_cycles    out  CNT_W  saturating count of stall cycles
//  flush_cycles    out  CNT_W  saturating count of squash cycles
// BEHAVIOUR
//  - Reset: state=RUN, flush_left=0, counters=0. Next-state/counter updates suppressed while reset=1.
//  - Outputs combinational from state + inputs. During reset: pc_write=if_id_write=id_ex_write=back_write=1,
//    flushes=0.
//  - Default (RUN, no event): all writes 1, flushes 0.
//  - Per-cycle priority (first match wins): FREEZE > BRANCH > LOAD_USE > IMEM_WAIT.
//  - FREEZE (dmem_req & !dmem_ready, any state): all writes 0, flushes 0; state and flush_left hold;
//    stall_cycles++.
//  - BRANCH (RUN & ex_branch_taken): pc_write=1, if_id_flush=1, id_ex_flush=1, back_write=1;
//    flush_cycles++; if FLUSH_CYCLES>1 -> FLUSH, flush_left=FLUSH_CYCLES-1; else stay RUN.
//  - LOAD_USE (RUN & ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))):
//    pc_write=0, if_id_write=0, id_ex_flush=1, back_write=1; stall_cycles++. Exactly one bubble per load:
//    the load leaves EX, so the condition clears.
//  - IMEM_WAIT (RUN & !imem_ready): pc_write=0, if_id_flush=1, id_ex/back proceed; stall_cycles++.
//  - FLUSH state (not frozen): pc_write=1, if_id_flush=1, id_ex_write=1, back_write=1; flush_cycles++;
//    flush_left--. When flush_left==1 this cycle -> RUN. Load-use, branch and imem_ready are ignored;
//    ID/EX hold bubbles.
//  - Counters saturate at all-ones; one increment max per cycle.
//  - Reset mid-FLUSH or mid-FREEZE: returns to RUN next edge; counters cleared.
//  - ex_rd==0 never causes a load-use stall.
// STRUCTURE
//  - riscv_pkg: state enum (RUN, FLUSH), REG_ADDR_W=5, NOP_INSTR=32'h00000013.
//  - Sub-module load_use_detect (combinational rs/rd compare -> lu_hazard).
//  - Top: 1-bit state reg, 2-bit flush_left, two saturating counters, priority output decode.
// TESTING
//  1. Reset 3 cycles then idle, imem_ready=1 -> all writes 1, flushes 0, counters 0.
//  2. ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for 1 cycle -> pc_write=0, if_id_write=0,
//     id_ex_flush=1; stall_cycles=1.
//  3. Same as 2 with ex_rd=0 -> no stall.
//  4. FLUSH_CYCLES=2, ex_branch_taken pulse -> if_id_flush=1 for 2 cycles, id_ex_flush on first only;
//     flush_cycles=2; back in RUN.
//  5. Branch then dmem_req=1, dmem_ready=0 for 3 cycles during FLUSH -> all writes 0 for 3 cycles,
//     FLUSH resumes for remaining 1 cycle; stall_cycles=3.
//  6. Load-use with !imem_ready and dmem stall same cycle -> freeze wins; then load-use; then imem bubble.
//     Assert reset mid-sequence -> RUN and counters 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage core: register address width, canonical NOP
// and the hazard sequencer state encoding.
package riscv_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } hz_state_e;

endpackage : riscv_pkg

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: the instruction in ID reads the register a load
// in EX is about to write. x0 is never a real dependency.
module load_use_detect
  import riscv_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  lu_hazard
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);
  assign lu_hazard = ex_mem_read && (ex_rd != '0) && (rs1_match || rs2_match);

endmodule : load_use_detect

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: prioritised decode of dmem freeze, branch squash, load-use
// bubble and imem bubble into stage enables, plus stall/flush perf counters.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  imem_ready,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_write,
  output logic                  id_ex_flush,
  output logic                  back_write,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_cycles
);

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  hz_state_e  state_q, state_d;
  logic [1:0] flush_left_q, flush_left_d;
  logic       lu_hazard;
  logic       freeze;
  logic [1:0] cnt_inc;   // [0] stall, [1] flush
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  load_use_detect u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .lu_hazard   (lu_hazard)
  );

  assign freeze = dmem_req && !dmem_ready;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    back_write   = 1'b1;
    state_d      = state_q;
    flush_left_d = flush_left_q;
    cnt_inc      = 2'b00;

    if (reset) begin
      // Enables stay at their free-running defaults; the flops clear themselves.
    end else if (freeze) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      back_write  = 1'b0;
      cnt_inc[0]  = 1'b1;
    end else if (state_q == ST_FLUSH) begin
      // Squash whatever the fetch path returns; ID/EX only ever sees bubbles here.
      if_id_flush  = 1'b1;
      cnt_inc[1]   = 1'b1;
      flush_left_d = flush_left_q - 2'd1;
      if (flush_left_q == 2'd1) begin
        state_d = ST_RUN;
      end
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      cnt_inc[1]  = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d      = ST_FLUSH;
        flush_left_d = FLUSH_INIT;
      end
    end else if (lu_hazard) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      cnt_inc[0]  = 1'b1;
    end else if (!imem_ready) begin
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
      cnt_inc[0]  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      flush_left_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      flush_left_q <= flush_left_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    always_comb begin
      cnt_d[gi] = cnt_q[gi];
      if (cnt_inc[gi] && (cnt_q[gi] != {CNT_W{1'b1}})) begin
        cnt_d[gi] = cnt_q[gi] + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q[gi] <= '0;
      end else begin
        cnt_q[gi] <= cnt_d[gi];
      end
    end
  end

  assign stall_cycles = cnt_q[0];
  assign flush_cycles = cnt_q[1];

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; control outputs are checked as one packed vector
// {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, back_write}.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic        imem_ready, dmem_req, dmem_ready;
  logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, back_write;
  logic [31:0] stall_cycles, flush_cycles;
  logic [5:0]  ctl;

  int checks   = 0;
  int failures = 0;

  localparam logic [5:0] C_RUN    = 6'b110101;
  localparam logic [5:0] C_FREEZE = 6'b000000;
  localparam logic [5:0] C_BRANCH = 6'b111111;
  localparam logic [5:0] C_LU     = 6'b000111;
  localparam logic [5:0] C_IMEM   = 6'b011101;
  localparam logic [5:0] C_FLUSH  = 6'b111101;

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .imem_ready      (imem_ready),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_write     (id_ex_write),
    .id_ex_flush     (id_ex_flush),
    .back_write      (back_write),
    .stall_cycles    (stall_cycles),
    .flush_cycles    (flush_cycles)
  );

  assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, back_write};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RUN);
    end
    repeat (3) step();
    reset = 1'b0;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      failures++; $display("FAIL idle_ctl got=%b exp=%b", ctl, C_RUN);
    end
    checks++;
    if (stall_cycles !== 32'd0 || flush_cycles !== 32'd0) begin
      failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cycles, flush_cycles);
    end
    $display("test_reset: ctl=%b stall=%0d flush=%0d", ctl, stall_cycles, flush_cycles);
  endtask

  task automatic test_load_use();
    set_load_use();
    #1;
    checks++;
    if (ctl !== C_LU) begin
      failures++; $display("FAIL lu_ctl got=%b exp=%b", ctl, C_LU);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      failures++; $display("FAIL lu_after_ctl got=%b exp=%b", ctl, C_RUN);
    end
    checks++;
    if (stall_cycles !== 32'd1) begin
      failures++; $display("FAIL lu_stall got=%0d exp=1", stall_cycles);
    end
    // rs1 path as well, different register
    ex_mem_read = 1'b1; ex_rd = 5'd17; id_rs1 = 5'd17; id_uses_rs1 = 1'b1;
    #1;
    checks++;
    if (ctl !== C_LU) begin
      failures++; $display("FAIL lu_rs1_ctl got=%b exp=%b", ctl, C_LU);
    end
    id_uses_rs1 = 1'b0;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      failures++; $display("FAIL lu_unused_ctl got=%b exp=%b", ctl, C_RUN);
    end
    idle_inputs();
    $display("test_load_use: stall=%0d", stall_cycles);
  endtask

  task automatic test_rd_zero();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      failures++; $display("FAIL rd0_ctl got=%b exp=%b", ctl, C_RUN);
    end
    step();
    idle_inputs();
    checks++;
    if (stall_cycles !== 32'd1) begin
      failures++; $display("FAIL rd0_stall got=%0d exp=1", stall_cycles);
    end
    $display("test_rd_zero: ctl=%b stall=%0d", ctl, stall_cycles);
  endtask

  task automatic test_branch();
    ex_branch_taken = 1'b1;
    #1;
    checks++;
    if (ctl !== C_BRANCH) begin
      failures++; $display("FAIL br_ctl got=%b exp=%b", ctl, C_BRANCH);
    end
    step();
    // In FLUSH: branch, load-use and imem_ready must all be ignored
    set_load_use();
    imem_ready = 1'b0;
    #1;
    checks++;
    if (ctl !== C_FLUSH) begin
      failures++; $display("FAIL flush_ctl got=%b exp=%b", ctl, C_FLUSH);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      failures++; $display("FAIL br_back_run got=%b exp=%b", ctl, C_RUN);
    end
    checks++;
    if (flush_cycles !== 32'd2 || stall_cycles !== 32'd1) begin
      failures++; $display("FAIL br_cnt got=%0d/%0d exp=1/2", stall_cycles, flush_cycles);
    end
    $display("test_branch: stall=%0d flush=%0d", stall_cycles, flush_cycles);
  endtask

  task automatic test_freeze_in_flush();
    do_reset();
    ex_branch_taken = 1'b1;
    step();
    ex_branch_taken = 1'b0;
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== C_FREEZE) begin
        failures++; $display("FAIL frz_ctl[%0d] got=%b exp=%b", i, ctl, C_FREEZE);
      end
      step();
    end
    dmem_req = 1'b0; dmem_ready = 1'b1;
    #1;
    checks++;
    if (ctl !== C_FLUSH) begin
      failures++; $display("FAIL frz_resume got=%b exp=%b", ctl, C_FLUSH);
    end
    step();
    checks++;
    if (ctl !== C_RUN) begin
      failures++; $display("FAIL frz_run got=%b exp=%b", ctl, C_RUN);
    end
    checks++;
    if (stall_cycles !== 32'd3 || flush_cycles !== 32'd2) begin
      failures++; $display("FAIL frz_cnt got=%0d/%0d exp=3/2", stall_cycles, flush_cycles);
    end
    $display("test_freeze_in_flush: stall=%0d flush=%0d", stall_cycles, flush_cycles);
  endtask

  task automatic test_priority();
    do_reset();
    set_load_use();
    imem_ready = 1'b0; dmem_req = 1'b1; dmem_ready = 1'b0;
    #1;
    checks++;
    if (ctl !== C_FREEZE) begin
      failures++; $display("FAIL pri_freeze got=%b exp=%b", ctl, C_FREEZE);
    end
    step();
    dmem_req = 1'b0; dmem_ready = 1'b1;
    #1;
    checks++;
    if (ctl !== C_LU) begin
      failures++; $display("FAIL pri_lu got=%b exp=%b", ctl, C_LU);
    end
    step();
    ex_mem_read = 1'b0;
    #1;
    checks++;
    if (ctl !== C_IMEM) begin
      failures++; $display("FAIL pri_imem got=%b exp=%b", ctl, C_IMEM);
    end
    step();
    checks++;
    if (stall_cycles !== 32'd3 || flush_cycles !== 32'd0) begin
      failures++; $display("FAIL pri_cnt got=%0d/%0d exp=3/0", stall_cycles, flush_cycles);
    end
    // Freeze with a branch pending holds RUN; the branch is taken once released
    ex_branch_taken = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
    step();
    dmem_req = 1'b0; dmem_ready = 1'b1; ex_mem_read = 1'b1;
    #1;
    checks++;
    if (ctl !== C_BRANCH) begin
      failures++; $display("FAIL pri_branch got=%b exp=%b", ctl, C_BRANCH);
    end
    step();
    idle_inputs();
    checks++;
    if (ctl !== C_FLUSH || flush_cycles !== 32'd1 || stall_cycles !== 32'd4) begin
      failures++; $display("FAIL pri_in_flush got=%b/%0d/%0d exp=%b/1/4", ctl, flush_cycles,
                           stall_cycles, C_FLUSH);
    end
    // Reset in the middle of FLUSH, with a freeze also requested
    reset = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      failures++; $display("FAIL rst_mid_ctl got=%b exp=%b", ctl, C_RUN);
    end
    step();
    reset = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (ctl !== C_RUN || stall_cycles !== 32'd0 || flush_cycles !== 32'd0) begin
      failures++; $display("FAIL rst_mid_state got=%b/%0d/%0d exp=%b/0/0", ctl, stall_cycles,
                           flush_cycles, C_RUN);
    end
    $display("test_priority: ctl=%b stall=%0d flush=%0d", ctl, stall_cycles, flush_cycles);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_rd_zero();
    test_branch();
    test_freeze_in_flush();
    test_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_hazard_ctrl
